backprop_stack_sequencer: RTL and testbench

Sequencer that drives the backpropagation stack: after a `start` pulse it walks layers from last to first and rows within each layer, emitting the packed 100-bit backprop control bundle one step per cycle. It sits directly upstream of the backprop stack controller, which unpacks the bundle into layer, row and strobe signals. A `step_ready` input lets downstream compute stall the walk.

---
 rtl/backprop_stack_sequencer.sv | 230 +++++++++++++++++++++++
 tb/tb_backprop_stack_sequencer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/backprop_stack_sequencer.sv
// -----------------------------------------------------------------------------
// backprop_stack_sequencer
//
// Walks the backpropagation stack after a start pulse. The pass runs from the
// last layer down to the first, and through every row of each layer. Each
// cycle it emits one step of the packed control bundle that the backprop
// stack controller consumes.
//
// Step order per pass:
//    CLEAR, then for each layer (last first):
//    CAL x size, STORE, and PROP (PROP is skipped after layer 0).
//    The pass ends with DONE.
//
// Optional feature:
//    `BACKPROP_ABORT_EN  adds the abort input. When abort is high outside
//                        IDLE, the next state is DONE.
//
// Ports:
//    clk                        in   rising-edge clock
//    reset_n                    in   asynchronous active-low reset
//    start                      in   begin a pass (sampled only in IDLE)
//    step_ready                 in   grant for the strobe of the next cycle
//    abort                      in   only with BACKPROP_ABORT_EN
//    backprop_controll_bundle   out  registered bundle:
//                                    [99:68] current_layer
//                                    [67:36] dc_dw_layer
//                                    [35:4]  dc_dw_row
//                                    [3]     update_storage
//                                    [2]     update_dy_dy_old
//                                    [1]     cal_dc_dw
//                                    [0]     reset
//    busy                       out  pass in progress (any state but IDLE)
//    done                       out  one-cycle pulse at the end of a pass
// -----------------------------------------------------------------------------
module backprop_stack_sequencer #(
   parameter logic [31:0] size                   = 32'd3,
   parameter logic [31:0] layer_count            = 32'd3,
   parameter int unsigned backprop_controll_size = 32'd32 * 32'd3 + 32'd4
) (
   input  logic                              clk,
   input  logic                              reset_n,
   input  logic                              start,
   input  logic                              step_ready,
`ifdef BACKPROP_ABORT_EN
   input  logic                              abort,
`endif
   output logic [backprop_controll_size-1:0] backprop_controll_bundle,
   output logic                              busy,
   output logic                              done
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLEAR = 3'd1,
      ST_CAL   = 3'd2,
      ST_STORE = 3'd3,
      ST_PROP  = 3'd4,
      ST_DONE  = 3'd5
   } state_t;

   state_t      state_q, state_d, state_walk_s;
   logic [31:0] layer_q, layer_d;
   logic [31:0] row_q, row_d;
   // High when the strobe of the current step is shown on the bundle.
   logic        emit_q, emit_d;
   logic        abort_s;

   logic [backprop_controll_size-1:0] bundle_q, bundle_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;

   logic [31:0] cur_layer_s, dc_layer_s, dc_row_s;
   logic [3:0]  strobe_s;

`ifdef BACKPROP_ABORT_EN
   assign abort_s = abort;
`else
   assign abort_s = 1'b0;
`endif

   // Walk state and counters.
   // step_ready sampled on an edge grants the strobe for the following cycle.
   // A step whose strobe was shown has been taken, so it always advances.
   // A stalled step stays pending until it is granted.
   always_comb begin
      state_walk_s = state_q;
      layer_d      = layer_q;
      row_d        = row_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_walk_s = ST_CLEAR;
               layer_d      = layer_count - 32'd1;
               row_d        = 32'd0;
            end else begin
               state_walk_s = ST_IDLE;
            end
         end
         ST_CLEAR: begin
            if (emit_q) begin
               state_walk_s = ST_CAL;
            end else begin
               state_walk_s = ST_CLEAR;
            end
         end
         ST_CAL: begin
            if (emit_q) begin
               if (row_q == size - 32'd1) begin
                  row_d        = 32'd0;
                  state_walk_s = ST_STORE;
               end else begin
                  row_d        = row_q + 32'd1;
               end
            end else begin
               state_walk_s = ST_CAL;
            end
         end
         ST_STORE: begin
            if (emit_q) begin
               if (layer_q == 32'd0) begin
                  state_walk_s = ST_DONE;
               end else begin
                  state_walk_s = ST_PROP;
               end
            end else begin
               state_walk_s = ST_STORE;
            end
         end
         ST_PROP: begin
            // PROP is entered only from a STORE with layer > 0.
            if (emit_q) begin
               layer_d      = layer_q - 32'd1;
               state_walk_s = ST_CAL;
            end else begin
               state_walk_s = ST_PROP;
            end
         end
         ST_DONE: begin
            state_walk_s = ST_IDLE;
         end
         default: begin
            state_walk_s = ST_IDLE;
            layer_d      = 32'd0;
            row_d        = 32'd0;
         end
      endcase
   end

   // Final next state: abort overrides the walk and the step_ready grant.
   always_comb begin
      state_d = state_walk_s;
      emit_d  = 1'b0;
      if (abort_s && (state_q != ST_IDLE) && (state_q != ST_DONE)) begin
         state_d = ST_DONE;
      end else begin
         state_d = state_walk_s;
      end
      case (state_d)
         ST_CLEAR, ST_CAL, ST_STORE, ST_PROP: emit_d = step_ready;
         default:                             emit_d = 1'b0;
      endcase
   end

   // Bundle fields and strobe for the step that becomes current on the next edge.
   always_comb begin
      cur_layer_s = 32'd0;
      dc_layer_s  = 32'd0;
      dc_row_s    = 32'd0;
      strobe_s    = 4'b0000;
      case (state_d)
         ST_CLEAR: begin
            strobe_s = 4'b0001;
         end
         ST_CAL: begin
            cur_layer_s = layer_d;
            dc_layer_s  = layer_d;
            dc_row_s    = row_d;
            strobe_s    = 4'b0010;
         end
         ST_STORE: begin
            cur_layer_s = layer_d;
            dc_layer_s  = layer_d;
            strobe_s    = 4'b1000;
         end
         ST_PROP: begin
            if (layer_d != 32'd0) begin
               cur_layer_s = layer_d - 32'd1;
            end else begin
               cur_layer_s = 32'd0;
            end
            dc_layer_s = layer_d;
            strobe_s   = 4'b0100;
         end
         default: begin
            strobe_s = 4'b0000;
         end
      endcase
      // A stall keeps the fields of the pending step but shows no strobe.
      bundle_d = {cur_layer_s, dc_layer_s, dc_row_s,
                  (emit_d ? strobe_s : 4'b0000)};
      busy_d   = (state_d != ST_IDLE);
      done_d   = (state_d == ST_DONE);
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         layer_q  <= 32'd0;
         row_q    <= 32'd0;
         emit_q   <= 1'b0;
         bundle_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         layer_q  <= layer_d;
         row_q    <= row_d;
         emit_q   <= emit_d;
         bundle_q <= bundle_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign backprop_controll_bundle = bundle_q;
   assign busy                     = busy_q;
   assign done                     = done_q;

endmodule

// File: tb/tb_backprop_stack_sequencer.sv
// -----------------------------------------------------------------------------
// Directed bench for backprop_stack_sequencer.
// dut_a: default parameters (size 3, layer_count 3).
// dut_b: size 1, layer_count 1.
// Cycle k of a pass is the k-th cycle after the edge that samples start.
// Outputs are read and inputs are driven on the falling edge.
// -----------------------------------------------------------------------------
module tb_backprop_stack_sequencer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start_a, start_b;
   logic        step_ready;
   logic        abort_s;
   logic [99:0] bundle_a, bundle_b;
   logic        busy_a, done_a, busy_b, done_b;

   int total = 0;
   int bad   = 0;

   logic [99:0] tab [1:16];
   logic [99:0] tab_b [1:4];
   logic [99:0] exp_v;

   always #5 clk = ~clk;

   backprop_stack_sequencer dut_a (
      .clk                      (clk),
      .reset_n                  (reset_n),
      .start                    (start_a),
      .step_ready               (step_ready),
`ifdef BACKPROP_ABORT_EN
      .abort                    (abort_s),
`endif
      .backprop_controll_bundle (bundle_a),
      .busy                     (busy_a),
      .done                     (done_a)
   );

   backprop_stack_sequencer #(.size(32'd1), .layer_count(32'd1)) dut_b (
      .clk                      (clk),
      .reset_n                  (reset_n),
      .start                    (start_b),
      .step_ready               (step_ready),
`ifdef BACKPROP_ABORT_EN
      .abort                    (1'b0),
`endif
      .backprop_controll_bundle (bundle_b),
      .busy                     (busy_b),
      .done                     (done_b)
   );

   // Strobe codes: 1 reset, 2 cal_dc_dw, 4 update_dy_dy_old, 8 update_storage.
   function automatic logic [99:0] mk(input logic [31:0] cur, input logic [31:0] dcl,
                                      input logic [31:0] row, input logic [3:0] st);
      return {cur, dcl, row, st};
   endfunction

   task automatic chk(input string tag, input logic [99:0] obs, input logic [99:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   initial begin
      reset_n    = 1'b0;
      start_a    = 1'b0;
      start_b    = 1'b0;
      step_ready = 1'b1;
      abort_s    = 1'b0;

      tab[1]  = mk(32'd0, 32'd0, 32'd0, 4'd1);
      tab[2]  = mk(32'd2, 32'd2, 32'd0, 4'd2);
      tab[3]  = mk(32'd2, 32'd2, 32'd1, 4'd2);
      tab[4]  = mk(32'd2, 32'd2, 32'd2, 4'd2);
      tab[5]  = mk(32'd2, 32'd2, 32'd0, 4'd8);
      tab[6]  = mk(32'd1, 32'd2, 32'd0, 4'd4);
      tab[7]  = mk(32'd1, 32'd1, 32'd0, 4'd2);
      tab[8]  = mk(32'd1, 32'd1, 32'd1, 4'd2);
      tab[9]  = mk(32'd1, 32'd1, 32'd2, 4'd2);
      tab[10] = mk(32'd1, 32'd1, 32'd0, 4'd8);
      tab[11] = mk(32'd0, 32'd1, 32'd0, 4'd4);
      tab[12] = mk(32'd0, 32'd0, 32'd0, 4'd2);
      tab[13] = mk(32'd0, 32'd0, 32'd1, 4'd2);
      tab[14] = mk(32'd0, 32'd0, 32'd2, 4'd2);
      tab[15] = mk(32'd0, 32'd0, 32'd0, 4'd8);
      tab[16] = 100'd0;

      tab_b[1] = mk(32'd0, 32'd0, 32'd0, 4'd1);
      tab_b[2] = mk(32'd0, 32'd0, 32'd0, 4'd2);
      tab_b[3] = mk(32'd0, 32'd0, 32'd0, 4'd8);
      tab_b[4] = 100'd0;

      // Reset state
      @(negedge clk);
      chk("rst bundle_a", bundle_a, 100'd0);
      chk("rst busy_a", 100'(busy_a), 100'd0);
      chk("rst done_a", 100'(done_a), 100'd0);
      chk("rst bundle_b", bundle_b, 100'd0);
      reset_n = 1'b1;
      @(negedge clk);

      // Pass 1: step_ready held high. start is raised in the DONE cycle and
      // must be ignored there, then accepted in the first IDLE cycle.
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         chk($sformatf("p1 c%0d bundle", k), bundle_a, tab[k]);
         chk($sformatf("p1 c%0d busy", k), 100'(busy_a), 100'd1);
         chk($sformatf("p1 c%0d done", k), 100'(done_a), 100'(k == 16));
         if (k == 16) start_a = 1'b1;
         @(negedge clk);
      end
      chk("p1 idle busy", 100'(busy_a), 100'd0);
      chk("p1 idle bundle", bundle_a, 100'd0);
      @(negedge clk);
      start_a = 1'b0;

      // Pass 2: starts from the first IDLE cycle. start is raised again in
      // cycle 5 and must be ignored. step_ready is low for the grants of
      // cycles 8, 9 and 10, so the layer-1 row-1 CAL is held until cycle 11.
      for (int k = 1; k <= 19; k++) begin
         if (k <= 7)       exp_v = tab[k];
         else if (k <= 10) exp_v = mk(32'd1, 32'd1, 32'd1, 4'd0);
         else              exp_v = tab[k-3];
         chk($sformatf("p2 c%0d bundle", k), bundle_a, exp_v);
         chk($sformatf("p2 c%0d busy", k), 100'(busy_a), 100'd1);
         chk($sformatf("p2 c%0d done", k), 100'(done_a), 100'(k == 19));
         if (k == 5)  start_a = 1'b1;
         if (k == 6)  start_a = 1'b0;
         if (k == 7)  step_ready = 1'b0;
         if (k == 10) step_ready = 1'b1;
         @(negedge clk);
      end
      chk("p2 end busy", 100'(busy_a), 100'd0);

      // Pass 3: reset_n pulsed during cycle 7, then a full restart.
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         chk($sformatf("p3 c%0d bundle", k), bundle_a, tab[k]);
         if (k < 7) @(negedge clk);
      end
      #1 reset_n = 1'b0;
      #1;
      chk("async rst bundle", bundle_a, 100'd0);
      chk("async rst busy", 100'(busy_a), 100'd0);
      chk("async rst done", 100'(done_a), 100'd0);
      #1 reset_n = 1'b1;
      @(negedge clk);
      chk("post rst busy", 100'(busy_a), 100'd0);
      chk("post rst bundle", bundle_a, 100'd0);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         chk($sformatf("replay c%0d bundle", k), bundle_a, tab[k]);
         @(negedge clk);
      end

      // size=1, layer_count=1: one CAL step, no PROP, done in cycle 4.
      start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         chk($sformatf("small c%0d bundle", k), bundle_b, tab_b[k]);
         chk($sformatf("small c%0d busy", k), 100'(busy_b), 100'd1);
         chk($sformatf("small c%0d done", k), 100'(done_b), 100'(k == 4));
         @(negedge clk);
      end
      chk("small idle busy", 100'(busy_b), 100'd0);
      chk("small idle done", 100'(done_b), 100'd0);

`ifdef BACKPROP_ABORT_EN
      // abort sampled at the end of cycle 8 gives DONE in cycle 9 and IDLE in cycle 10.
      repeat (20) @(negedge clk);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         if (k <= 8) exp_v = tab[k];
         else        exp_v = 100'd0;
         chk($sformatf("abort c%0d bundle", k), bundle_a, exp_v);
         chk($sformatf("abort c%0d busy", k), 100'(busy_a), 100'(k <= 9));
         chk($sformatf("abort c%0d done", k), 100'(done_a), 100'(k == 9));
         if (k == 8) abort_s = 1'b1;
         if (k == 9) abort_s = 1'b0;
         @(negedge clk);
      end
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
